// File: rtl/img_stream_pkg.sv
// Shared constants and FSM state encoding for the image line streaming path.
package img_stream_pkg;

  // Default frame geometry and flow-control depth.
  localparam int IMG_WIDTH   = 512;
  localparam int IMG_HEIGHT  = 512;
  localparam int PRIME_LINES = 4;
  localparam int ADDR_W      = 18;
  localparam int PIX_W       = 8;

  // Sender FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_WAIT_CREDIT = 2'd1;
  localparam state_t ST_SEND_LINE   = 2'd2;
  localparam state_t ST_DRAIN       = 2'd3;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO carrying data plus an end-of-line tag; its head
// drives the AXI-Stream master outputs directly, so the head entry stays
// put while the consumer stalls.
module pixel_skid_fifo
  import img_stream_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [PIX_W-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [PIX_W-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [1:0][PIX_W-1:0] data_q;
  logic [1:0]            last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  assign valid_o = (count_q != 2'd0);
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy tracks pushes and pops landing in the same cycle.
  always_comb begin
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Storage and pointers; storage is cleared so the outputs read zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/image_line_sender.sv
// Streams a frame out of pixel memory line by line over AXI-Stream. Each
// line needs a credit from the downstream processor; credits are primed at
// frame start and returned one per i_intr pulse.
module image_line_sender #(
  parameter int IMG_WIDTH   = img_stream_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = img_stream_pkg::IMG_HEIGHT,
  parameter int PRIME_LINES = img_stream_pkg::PRIME_LINES,
  parameter int ADDR_W      = img_stream_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  output logic              o_data_last,
  input  logic              i_data_ready,
  input  logic              i_intr
);

  import img_stream_pkg::*;

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CRD_W = $clog2(PRIME_LINES + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(PRIME_LINES);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CRD_W-1:0]  credit_q, credit_d;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              done_q;

  logic              fifo_valid;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [2:0]        pending;
  logic              rd_en;
  logic              col_last;
  logic              row_last;
  logic              start_ok;
  logic              consume;
  logic              intr_ok;
  logic              final_beat;

  // A read may go out only if its data is guaranteed a FIFO slot; an entry
  // leaving this cycle frees its slot, which keeps a line at one pixel/cycle.
  assign fifo_pop   = fifo_valid && i_data_ready;
  assign pending    = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, fifo_pop};
  assign rd_en      = (state_q == ST_SEND_LINE) && (pending < 3'd2);
  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  assign start_ok   = (state_q == ST_IDLE) && i_start;
  assign consume    = (state_q == ST_WAIT_CREDIT) && (credit_q != '0);
  assign intr_ok    = i_intr && (state_q != ST_IDLE);
  assign final_beat = (state_q == ST_DRAIN) && fifo_pop && (fifo_count == 2'd1) && !inflight_q;

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_rd_en   = rd_en;
  assign o_rd_addr = addr_q;

  // Frame sequencing: wait for a credit, send one line, repeat, then drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (i_start) state_d = ST_WAIT_CREDIT;
      ST_WAIT_CREDIT: if (consume) state_d = ST_SEND_LINE;
      ST_SEND_LINE:   if (rd_en && col_last) state_d = row_last ? ST_DRAIN : ST_WAIT_CREDIT;
      ST_DRAIN:       if (final_beat) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Credit bookkeeping; a returned credit and a consumed one cancel out.
  always_comb begin
    credit_d = credit_q;
    if (start_ok) begin
      credit_d = CRD_MAX;
    end else if (consume && !intr_ok) begin
      credit_d = credit_q - CRD_W'(1);
    end else if (intr_ok && !consume && (credit_q < CRD_MAX)) begin
      credit_d = credit_q + CRD_W'(1);
    end
  end

  // Row-major read address walk; wraps to zero after the last pixel so the
  // address never runs past the frame.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (start_ok) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (rd_en) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_q + ROW_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // State registers; the in-flight flag marks the cycle read data returns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      col_q           <= '0;
      row_q           <= '0;
      addr_q          <= '0;
      credit_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      row_q           <= row_d;
      addr_q          <= addr_d;
      credit_q        <= credit_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && col_last;
      done_q          <= final_beat;
    end
  end

  pixel_skid_fifo u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .push_i      (inflight_q),
    .push_data_i (i_rd_data),
    .push_last_i (inflight_last_q),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .data_o      (o_data),
    .last_o      (o_data_last),
    .count_o     (fifo_count)
  );

  assign o_data_valid = fifo_valid;

endmodule

// File: tb/tb_image_line_sender.sv
// Bench for image_line_sender on an 8x6 frame with memory[a] = a.
module tb_image_line_sender;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int P    = 4;
  localparam int AW   = 18;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_intr;
  logic          i_data_ready;
  logic [7:0]    i_rd_data;
  logic          o_busy;
  logic          o_done;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_data_valid;
  logic [7:0]    o_data;
  logic          o_data_last;

  int checks    = 0;
  int errors    = 0;
  int rxCount   = 0;
  int expAddr   = 0;
  int doneCount = 0;
  int cycleCnt  = 0;
  int coincAddr = 0;
  int rdCycle [NPIX];

  bit autoIntr   = 1'b0;
  bit randReady  = 1'b0;
  bit coincEn    = 1'b0;
  bit manualIntr = 1'b0;
  bit pendIntr   = 1'b0;
  bit coincPend  = 1'b0;
  bit pendRd     = 1'b0;
  logic [7:0] pendData  = 8'h00;
  logic       prevStall = 1'b0;
  logic [7:0] prevData  = 8'h00;
  logic       prevLast  = 1'b0;

  always #5 clk = ~clk;

  image_line_sender #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PRIME_LINES (P),
    .ADDR_W      (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_data_last  (o_data_last),
    .i_data_ready (i_data_ready),
    .i_intr       (i_intr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus();
    rxCount   = 0;
    expAddr   = 0;
    doneCount = 0;
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic waitBeats(input int n, input int budget, input string tag);
    int k = 0;
    while (rxCount < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(rxCount), 32'(n));
  endtask

  task automatic waitDone(input int budget, input string tag);
    int k = 0;
    while (doneCount == 0 && k < budget) begin
      tick();
      k++;
    end
    checkOutput({tag, "_done"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "_beats"}, 32'(rxCount), 32'(NPIX));
    checkOutput({tag, "_reads"}, 32'(expAddr), 32'(NPIX));
  endtask

  // Reference stream: beat n carries n and is tagged on the last column;
  // reads must walk 0..NPIX-1; the memory answers one cycle after a read.
  always @(negedge clk) begin
    cycleCnt++;
    if (i_rst === 1'b1) begin
      prevStall = 1'b0;
      pendRd    = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("holdValid", 32'(o_data_valid), 32'd1);
        checkOutput("holdData", 32'(o_data), 32'(prevData));
        checkOutput("holdLast", 32'(o_data_last), 32'(prevLast));
      end
      if (o_rd_en === 1'b1) begin
        checkOutput("rdAddr", 32'(o_rd_addr), 32'(expAddr));
        if (expAddr >= 0 && expAddr < NPIX) rdCycle[expAddr] = cycleCnt;
        if (coincEn && expAddr == coincAddr) coincPend = 1'b1;
        expAddr++;
        pendRd   = 1'b1;
        pendData = o_rd_addr[7:0];
      end else begin
        pendRd = 1'b0;
      end
      if (o_data_valid === 1'b1 && i_data_ready === 1'b1) begin
        checkOutput("beatData", 32'(o_data), 32'(rxCount % 256));
        checkOutput("beatLast", 32'(o_data_last), 32'((rxCount % W) == (W - 1)));
        if (o_data_last === 1'b1) pendIntr = 1'b1;
        rxCount++;
      end
      if (o_done === 1'b1) doneCount++;
      prevStall = (o_data_valid === 1'b1) && (i_data_ready === 1'b0);
      prevData  = o_data;
      prevLast  = o_data_last;
    end
  end

  // Downstream and memory side: read data, ready and credit-return pulses.
  initial begin
    i_intr       = 1'b0;
    i_data_ready = 1'b1;
    i_rd_data    = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      i_rd_data    = pendRd ? pendData : 8'($urandom);
      i_data_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      i_intr       = (autoIntr && pendIntr) || manualIntr || coincPend;
      pendIntr     = 1'b0;
      manualIntr   = 1'b0;
      coincPend    = 1'b0;
    end
  end

  // Directed sequence of frame scenarios.
  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstRdEn", 32'(o_rd_en), 32'd0);
    checkOutput("rstRdAddr", 32'(o_rd_addr), 32'd0);
    checkOutput("rstValid", 32'(o_data_valid), 32'd0);
    checkOutput("rstData", 32'(o_data), 32'd0);
    checkOutput("rstLast", 32'(o_data_last), 32'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    idleCycles(2);

    // Full frame with ready high and a credit returned after every line.
    autoIntr = 1'b1;
    applyStimulus();
    tick();
    checkOutput("latBusy", 32'(o_busy), 32'd1);
    checkOutput("latValid1", 32'(o_data_valid), 32'd0);
    tick();
    checkOutput("latValid2", 32'(o_data_valid), 32'd0);
    tick();
    checkOutput("latValid3", 32'(o_data_valid), 32'd0);
    tick();
    checkOutput("latValid4", 32'(o_data_valid), 32'd1);
    checkOutput("latFirstData", 32'(o_data), 32'd0);
    waitDone(400, "fullFrame");
    checkOutput("fullBusyAfter", 32'(o_busy), 32'd0);
    checkOutput("fullLineGap", 32'(rdCycle[5] - rdCycle[4]), 32'd1);
    idleCycles(5);

    // No credit returns: four primed lines, then one pulse releases one line.
    autoIntr = 1'b0;
    applyStimulus();
    waitBeats(P * W, 400, "primeBeats");
    idleCycles(40);
    checkOutput("primeStall", 32'(rxCount), 32'(P * W));
    checkOutput("primeBusy", 32'(o_busy), 32'd1);
    manualIntr = 1'b1;
    waitBeats((P + 1) * W, 400, "oneCreditBeats");
    idleCycles(40);
    checkOutput("oneCreditStall", 32'(rxCount), 32'((P + 1) * W));
    manualIntr = 1'b1;
    waitDone(400, "creditFrame");
    idleCycles(5);

    // Random backpressure.
    autoIntr  = 1'b1;
    randReady = 1'b1;
    applyStimulus();
    waitDone(3000, "randFrame");
    randReady = 1'b0;
    idleCycles(5);

    // Credit return coincident with consumption at credit 1.
    autoIntr  = 1'b0;
    coincEn   = 1'b1;
    coincAddr = 3 * W - 1;
    applyStimulus();
    waitBeats((P + 1) * W, 400, "coincBeats");
    idleCycles(40);
    checkOutput("coincStall", 32'(rxCount), 32'((P + 1) * W));
    checkOutput("coincGap", 32'(rdCycle[P * W] - rdCycle[P * W - 1]), 32'd2);
    coincEn    = 1'b0;
    manualIntr = 1'b1;
    waitDone(400, "coincFrame");
    idleCycles(5);

    // Reset mid-frame aborts silently; the next frame restarts at zero.
    autoIntr = 1'b1;
    applyStimulus();
    waitBeats(20, 400, "abortBeats");
    @(posedge clk);
    #1 i_rst = 1'b1;
    doneCount = 0;
    repeat (2) @(posedge clk);
    tick();
    checkOutput("abortBusy", 32'(o_busy), 32'd0);
    checkOutput("abortValid", 32'(o_data_valid), 32'd0);
    checkOutput("abortRdAddr", 32'(o_rd_addr), 32'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    idleCycles(10);
    checkOutput("abortNoDone", 32'(doneCount), 32'd0);
    applyStimulus();
    waitDone(400, "restartFrame");
    idleCycles(5);

    // A second start mid-frame is ignored.
    applyStimulus();
    waitBeats(10, 400, "reStartBeats");
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    waitDone(400, "reStartFrame");
    idleCycles(10);
    checkOutput("reStartBusy", 32'(o_busy), 32'd0);
    checkOutput("reStartDoneCount", 32'(doneCount), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
